// File: rtl/dfifo_pkg.sv
// Shared helpers for the dfifo block: parameter legality check used at elaboration.
package dfifo_pkg;

  function automatic bit is_legal_depth(int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/dfifo_mem.sv
// DEPTH x DIN register array: synchronous write port, asynchronous read port.
module dfifo_mem #(
  parameter int DIN    = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DIN-1:0]    wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DIN-1:0]    rdata_o
);

  logic [DIN-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; occupancy lives in the pointers, so stale
  // words are never presented as valid and a reset tree here buys nothing.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dfifo.sv
// Synchronous FIFO on valid/ready handshakes; din_ready_o depends only on occupancy.
module dfifo
  import dfifo_pkg::*;
#(
  parameter int DIN   = 16,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DIN-1:0] din_data_i,
  input  logic           din_valid_i,
  output logic           din_ready_o,
  output logic [DIN-1:0] dout_data_o,
  output logic           dout_valid_o,
  input  logic           dout_ready_i
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  if (!is_legal_depth(DEPTH)) begin : g_bad_depth
    $error("dfifo: DEPTH must be a power of two and >= 2");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             empty, full;
  logic             do_write, do_read;

  // The extra pointer MSB is the wrap flag that tells full apart from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  assign din_ready_o  = !full;
  assign dout_valid_o = !empty;
  assign do_write     = din_valid_i && !full;
  assign do_read      = dout_ready_i && !empty;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_write) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_read)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  dfifo_mem #(
    .DIN   (DIN),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk    (clk),
    .we_i   (do_write),
    .waddr_i(wr_ptr_q[ADDR_W-1:0]),
    .wdata_i(din_data_i),
    .raddr_i(rd_ptr_q[ADDR_W-1:0]),
    .rdata_o(dout_data_o)
  );

endmodule

// File: tb/tb_dfifo.sv
// Self-checking bench for dfifo: queue-based reference model plus directed and random traffic.
module tb_dfifo;

  localparam int DIN   = 16;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DIN-1:0] din_data = '0;
  logic           din_valid = 1'b0;
  logic           din_ready;
  logic [DIN-1:0] dout_data;
  logic           dout_valid;
  logic           dout_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DIN-1:0] model_q [$];
  bit             stall_q = 1'b0;
  logic [DIN-1:0] hold_data = '0;

  always #5 clk = ~clk;

  dfifo #(.DIN(DIN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .din_data_i  (din_data),
    .din_valid_i (din_valid),
    .din_ready_o (din_ready),
    .dout_data_o (dout_data),
    .dout_valid_o(dout_valid),
    .dout_ready_i(dout_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare against the model,
  // then let the model take the rising edge exactly as the handshake rules say.
  task automatic step(input logic v, input logic [DIN-1:0] d, input logic r);
    bit acc, rd;
    @(negedge clk);
    din_valid  = v;
    din_data   = d;
    dout_ready = r;
    #1;
    check("dout_valid", 32'(dout_valid), 32'(model_q.size() != 0));
    check("din_ready", 32'(din_ready), 32'(model_q.size() < DEPTH));
    if (model_q.size() != 0) check("dout_data", 32'(dout_data), 32'(model_q[0]));
    if (stall_q) begin
      check("hold_valid", 32'(dout_valid), 32'd1);
      check("hold_data", 32'(dout_data), 32'(hold_data));
    end
    stall_q   = dout_valid && !r;
    hold_data = dout_data;
    acc = v && (model_q.size() < DEPTH);
    rd  = r && (model_q.size() != 0);
    @(posedge clk);
    if (rd)  void'(model_q.pop_front());
    if (acc) model_q.push_back(d);
    #1;
  endtask

  initial begin
    // Reset held across a few edges, then idle.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 16'($urandom), 1'($urandom));

    // Fill with no reader, offer a 5th word that must wait.
    for (int k = 1; k <= 4; k++) step(1'b1, 16'(16'h11 * k), 1'b0);
    check("fill_full", 32'(din_ready), 32'd0);
    step(1'b1, 16'h55, 1'b0);
    step(1'b1, 16'h55, 1'b0);
    check("full_head", 32'(dout_data), 32'h11);
    step(1'b1, 16'h55, 1'b1);
    check("after_rd_ready", 32'(din_ready), 32'd1);
    check("after_rd_head", 32'(dout_data), 32'h22);
    step(1'b1, 16'h55, 1'b1);
    check("55_accepted", 32'(din_ready), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1);
    check("drained", 32'(dout_valid), 32'd0);

    // Continuous streaming 0..19 through five pointer wraps.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'(i), 1'b1);
      check("stream_head", 32'(dout_data), 32'(i));
    end
    step(1'b0, 16'h0, 1'b1);
    check("stream_empty", 32'(dout_valid), 32'd0);

    // Full FIFO with a one-cycle read while a writer waits.
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'hA0 + i), 1'b0);
    step(1'b1, 16'hB0, 1'b1);
    check("one_read_ready", 32'(din_ready), 32'd1);
    check("one_read_head", 32'(dout_data), 32'hA1);
    step(1'b1, 16'hB0, 1'b0);
    check("refull", 32'(din_ready), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1);

    // Random backpressure and random offers.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));

    // Asynchronous reset mid-stream with three words queued.
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'hC0 + i), 1'b0);
    check("pre_rst_valid", 32'(dout_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", 32'(dout_valid), 32'd0);
    check("async_ready", 32'(din_ready), 32'd1);
    model_q.delete();
    stall_q = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
    #1;
    step(1'b1, 16'hD5, 1'b0);
    check("post_rst_head", 32'(dout_data), 32'hD5);
    step(1'b1, 16'hD6, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
